// File: rtl/machine_timer_pkg.sv
// -----------------------------------------------------------------------------
// machine_timer_pkg
// Shared constants for the memory-mapped machine timer: bus control constants,
// register word offsets, CTRL/STATUS bit positions and reset values.
// -----------------------------------------------------------------------------
package machine_timer_pkg;

    // Bus / reset control constants shared with the rest of the peripheral bus.
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        WriteEnable = 1'b1;
    localparam logic        RstEnable   = 1'b1;

    // Register select, taken from addr_i[3:2].
    typedef enum logic [1:0] {
        TMR_CTRL   = 2'd0,   // byte offset 0x0
        TMR_STATUS = 2'd1,   // byte offset 0x4
        TMR_COUNT  = 2'd2,   // byte offset 0x8
        TMR_CMP    = 2'd3    // byte offset 0xC
    } tmr_reg_e;

    // CTRL bit positions.
    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_PERIODIC_BIT = 1;
    localparam int CTRL_IE_BIT       = 2;
    localparam int CTRL_DIV_LSB      = 8;

    // STATUS bit positions.
    localparam int STATUS_PEND_BIT   = 0;

    // Control flag group held in CTRL (DIV is kept separately, its width is a
    // module parameter).
    typedef struct packed {
        logic ie;
        logic periodic;
        logic en;
    } ctrl_flags_t;

    localparam ctrl_flags_t CTRL_FLAGS_RST = '{ie: 1'b0, periodic: 1'b0, en: 1'b0};
    localparam logic        PEND_RST       = 1'b0;

endpackage : machine_timer_pkg

// File: rtl/machine_timer_prescaler.sv
// -----------------------------------------------------------------------------
// machine_timer_prescaler
// Divides the clock into count ticks. The internal counter runs 0..div_i while
// enabled and tick_o is high in the cycle it equals div_i, after which it
// restarts at 0. div_i == 0 therefore ticks every enabled cycle.
//
// Ports
//   clk     in   clock
//   rst     in   asynchronous reset, active-high
//   en_i    in   count enable; low holds the counter at 0
//   clr_i   in   synchronous restart of the counter (CTRL write)
//   div_i   in   divider value, PSC_W bits
//   tick_o  out  one-cycle count tick
// -----------------------------------------------------------------------------
module machine_timer_prescaler
    import machine_timer_pkg::*;
#(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [PSC_W-1:0] div_i,
    output logic             tick_o
);

    logic [PSC_W-1:0] psc_q;
    logic [PSC_W-1:0] psc_d;

    assign tick_o = en_i && (psc_q == div_i);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; otherwise a latch is inferred.
        psc_d = psc_q + PSC_W'(1);
        if (clr_i || !en_i || tick_o) begin
            psc_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

endmodule : machine_timer_prescaler

// File: rtl/machine_timer.sv
// -----------------------------------------------------------------------------
// machine_timer
// Memory-mapped machine timer. A prescaled DW-bit up-counter (COUNT) is compared
// against CMP on every count tick; a match sets PEND, which is presented to the
// core local interruptor as a level request when IE is set. The interruptor
// acknowledges with a one-cycle int_ack_i that clears PEND.
//
// Register map (word offsets, addr_i[1:0] must be 0, bits above [3] must be 0)
//   0x0 CTRL    [0] EN, [1] PERIODIC, [2] IE, [8 +: PSC_W] DIV
//   0x4 STATUS  [0] PEND, write 1 to clear
//   0x8 COUNT   counter value, R/W
//   0xC CMP     compare value, R/W
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous reset, active-high
//   we_i       in   write enable, one cycle per write
//   addr_i     in   register byte address
//   data_i     in   write data
//   data_o     out  read data, combinational from addr_i (0 during reset)
//   int_req_o  out  timer interrupt request, level
//   int_ack_i  in   one-cycle acknowledge, clears PEND
// -----------------------------------------------------------------------------
module machine_timer
    import machine_timer_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int PSC_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o,
    output logic          int_req_o,
    input  logic          int_ack_i
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ctrl_flags_t      ctrl_q,  ctrl_d;
    logic [PSC_W-1:0] div_q,   div_d;
    logic             pend_q,  pend_d;
    logic [DW-1:0]    count_q, count_d;
    logic [DW-1:0]    cmp_q,   cmp_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic     addr_hit;
    tmr_reg_e reg_sel;
    logic     wr_ctrl, wr_status, wr_count, wr_cmp;

    assign addr_hit  = (addr_i[1:0] == 2'b00) && (addr_i[AW-1:4] == '0);
    assign reg_sel   = tmr_reg_e'(addr_i[3:2]);

    assign wr_ctrl   = (we_i == WriteEnable) && addr_hit && (reg_sel == TMR_CTRL);
    assign wr_status = (we_i == WriteEnable) && addr_hit && (reg_sel == TMR_STATUS);
    assign wr_count  = (we_i == WriteEnable) && addr_hit && (reg_sel == TMR_COUNT);
    assign wr_cmp    = (we_i == WriteEnable) && addr_hit && (reg_sel == TMR_CMP);

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic tick;

    machine_timer_prescaler #(
        .PSC_W (PSC_W)
    ) u_timer_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en_i   (ctrl_q.en),
        .clr_i  (wr_ctrl),
        .div_i  (div_q),
        .tick_o (tick)
    );

    // tick is only ever high while EN is set, so a match event needs no
    // separate EN qualification.
    logic match_evt;
    assign match_evt = tick && (count_q == cmp_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d  = ctrl_q;
        div_d   = div_q;
        pend_d  = pend_q;
        count_d = count_q;
        cmp_d   = cmp_q;

        // Counter: reload or stop on a match, otherwise increment (wrapping
        // silently). A bus write to COUNT overrides the tick update.
        if (tick) begin
            if (count_q == cmp_q) begin
                if (ctrl_q.periodic) begin
                    count_d = '0;
                end else begin
                    ctrl_d.en = 1'b0;
                end
            end else begin
                count_d = count_q + DW'(1);
            end
        end
        if (wr_count) begin
            count_d = data_i;
        end

        // A CTRL write replaces the whole register, including a one-shot
        // stop raised in the same cycle.
        if (wr_ctrl) begin
            ctrl_d.en       = data_i[CTRL_EN_BIT];
            ctrl_d.periodic = data_i[CTRL_PERIODIC_BIT];
            ctrl_d.ie       = data_i[CTRL_IE_BIT];
            div_d           = data_i[CTRL_DIV_LSB +: PSC_W];
        end

        if (wr_cmp) begin
            cmp_d = data_i;
        end

        // Pending: clear by acknowledge or W1C, but a same-cycle match wins
        // so no interrupt is dropped.
        if (int_ack_i || (wr_status && data_i[STATUS_PEND_BIT])) begin
            pend_d = 1'b0;
        end
        if (match_evt) begin
            pend_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            ctrl_q  <= CTRL_FLAGS_RST;
            div_q   <= '0;
            pend_q  <= PEND_RST;
            count_q <= '0;
            cmp_q   <= '1;
        end else begin
            ctrl_q  <= ctrl_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign int_req_o = pend_q & ctrl_q.ie;

    always_comb begin
        data_o = DW'(ZeroWord);
        if ((rst != RstEnable) && addr_hit) begin
            unique case (reg_sel)
                TMR_CTRL: begin
                    data_o[CTRL_EN_BIT]             = ctrl_q.en;
                    data_o[CTRL_PERIODIC_BIT]       = ctrl_q.periodic;
                    data_o[CTRL_IE_BIT]             = ctrl_q.ie;
                    data_o[CTRL_DIV_LSB +: PSC_W]   = div_q;
                end
                TMR_STATUS: data_o[STATUS_PEND_BIT] = pend_q;
                TMR_COUNT:  data_o = count_q;
                TMR_CMP:    data_o = cmp_q;
                default:    data_o = DW'(ZeroWord);
            endcase
        end
    end

endmodule : machine_timer

// File: tb/tb_machine_timer.sv
// -----------------------------------------------------------------------------
// tb_machine_timer
// Self-checking bench for machine_timer. A driver issues one bus cycle per
// clock and pushes the expected data_o / int_req_o for that cycle into a
// scoreboard queue; a monitor pops and compares on the falling edge. Expected
// values come from a behavioural register model or from directed constants.
// -----------------------------------------------------------------------------
module tb_machine_timer;

    localparam logic [31:0] A_CTRL   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_COUNT  = 32'h8;
    localparam logic [31:0] A_CMP    = 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        int_req_o;
    logic        int_ack_i;

    always #5 clk = ~clk;

    machine_timer #(
        .DW    (32),
        .AW    (32),
        .PSC_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .int_req_o (int_req_o),
        .int_ack_i (int_ack_i)
    );

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] data;
        logic        irq;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input logic [31:0] act, input logic [31:0] exp, input string name);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (data_o !== e.data || int_req_o !== e.irq) begin
                    failures++;
                    $display("FAIL %s: data_o=%h int_req_o=%b expected data_o=%h int_req_o=%b",
                             e.name, data_o, int_req_o, e.data, e.irq);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: register-level view of the timer
    // ------------------------------------------------------------------
    logic        m_en, m_per, m_ie, m_pend;
    logic [7:0]  m_div;
    logic [31:0] m_count, m_cmp;
    int          m_phase;   // cycles since the prescaler restarted, mod DIV+1

    function automatic void model_reset();
        m_en = 0; m_per = 0; m_ie = 0; m_pend = 0;
        m_div = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF; m_phase = 0;
    endfunction

    function automatic logic mapped(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'h10);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!mapped(a)) return 32'h0;
        case (a)
            A_CTRL:   return {16'h0, m_div, 5'h0, m_ie, m_per, m_en};
            A_STATUS: return {31'h0, m_pend};
            A_COUNT:  return m_count;
            default:  return m_cmp;
        endcase
    endfunction

    function automatic void model_step(input logic we, input logic [31:0] a,
                                       input logic [31:0] d, input logic ack);
        logic        tick, match;
        logic [31:0] n_count;
        logic        n_en, n_pend;
        int          n_phase;
        tick  = m_en && (m_phase == int'(m_div));
        match = (m_count == m_cmp);

        if ((we && a == A_CTRL) || !m_en) n_phase = 0;
        else                              n_phase = (m_phase + 1) % (int'(m_div) + 1);

        n_count = m_count;
        n_en    = m_en;
        if (tick && match) begin
            if (m_per) n_count = 0;
            else       n_en = 0;
        end else if (tick) begin
            n_count = m_count + 1;
        end
        if (we && a == A_COUNT) n_count = d;

        n_pend = m_pend;
        if (ack || (we && a == A_STATUS && d[0])) n_pend = 0;
        if (tick && match) n_pend = 1;

        if (we && a == A_CTRL) begin
            n_en = d[0]; m_per = d[1]; m_ie = d[2]; m_div = d[15:8];
        end
        if (we && a == A_CMP) m_cmp = d;

        m_count = n_count; m_en = n_en; m_pend = n_pend; m_phase = n_phase;
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks: called at posedge+1, return at the next posedge+1
    // ------------------------------------------------------------------
    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic ack, input logic use_c, input logic [31:0] c_data,
                         input logic c_irq, input string name);
        exp_t e;
        we_i = we; addr_i = a; data_i = d; int_ack_i = ack;
        e.data = use_c ? c_data : model_read(a);
        e.irq  = use_c ? c_irq  : (m_pend & m_ie);
        e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        model_step(we, a, d, ack);
        #1;
        we_i = 1'b0; int_ack_i = 1'b0;
    endtask

    task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic ack, input string name);
        drive(we, a, d, ack, 1'b0, 32'h0, 1'b0, name);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, a, d, 1'b0, 1'b0, 32'h0, 1'b0, "bus_write");
    endtask

    task automatic expect_c(input logic [31:0] a, input logic [31:0] exp_data,
                            input logic exp_irq, input string name);
        drive(1'b0, a, 32'h0, 1'b0, 1'b1, exp_data, exp_irq, name);
    endtask

    task automatic collide(input logic use_ack);
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);
        wr(A_COUNT, 32'd3);
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'h7);
        if (use_ack) cyc(1'b0, A_STATUS, 32'h0, 1'b1, "ack_on_match");
        else         cyc(1'b1, A_STATUS, 32'h1, 1'b0, "w1c_on_match");
        expect_c(A_STATUS, 32'h1, 1'b1, use_ack ? "pend_after_ack_collision"
                                                : "pend_after_w1c_collision");
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] addr_tbl [7];
        addr_tbl = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h2, 32'h18};

        // Reset at time zero.
        rst = 1'b1; we_i = 0; int_ack_i = 0; addr_i = A_CMP; data_i = 0;
        model_reset();
        #2;
        check({31'h0, int_req_o}, 32'h0, "reset_irq");
        check(data_o, 32'h0, "reset_data_gated");
        @(posedge clk); #1;
        rst = 1'b0;
        expect_c(A_CTRL,   32'h0,         1'b0, "reset_ctrl");
        expect_c(A_COUNT,  32'h0,         1'b0, "reset_count");
        expect_c(A_CMP,    32'hFFFF_FFFF, 1'b0, "reset_cmp");
        expect_c(A_STATUS, 32'h0,         1'b0, "reset_status");

        // One-shot: DIV=4, CMP=2, EN|IE.
        wr(A_CMP, 32'd2);
        wr(A_CTRL, 32'h405);
        repeat (20) cyc(1'b0, A_COUNT, 32'h0, 1'b0, "oneshot_count");
        expect_c(A_CTRL,   32'h404, 1'b1, "oneshot_en_cleared");
        expect_c(A_COUNT,  32'd2,   1'b1, "oneshot_count_held");
        expect_c(A_STATUS, 32'h1,   1'b1, "oneshot_pend");

        // Asynchronous reset mid-cycle while the interrupt is asserted.
        addr_i = A_CTRL;
        #3 rst = 1'b1;
        #1;
        check({31'h0, int_req_o}, 32'h0, "async_reset_irq");
        check(data_o, 32'h0, "async_reset_data");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        expect_c(A_CTRL,  32'h0,         1'b0, "async_reset_ctrl");
        expect_c(A_COUNT, 32'h0,         1'b0, "async_reset_count");
        expect_c(A_CMP,   32'hFFFF_FFFF, 1'b0, "async_reset_cmp");

        // Periodic: CMP=3, DIV=0, EN|PERIODIC|IE.
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'h7);
        expect_c(A_COUNT, 32'd0, 1'b0, "periodic_c0");
        expect_c(A_COUNT, 32'd1, 1'b0, "periodic_c1");
        expect_c(A_COUNT, 32'd2, 1'b0, "periodic_c2");
        expect_c(A_COUNT, 32'd3, 1'b0, "periodic_c3");
        expect_c(A_COUNT, 32'd0, 1'b1, "periodic_reload_irq");
        cyc(1'b0, A_STATUS, 32'h0, 1'b1, "periodic_ack");
        expect_c(A_STATUS, 32'h0, 1'b0, "periodic_acked");
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);

        // Collisions.
        collide(1'b1);
        collide(1'b0);
        wr(A_STATUS, 32'h1);
        wr(A_COUNT, 32'h10);
        expect_c(A_COUNT, 32'h10, 1'b0, "count_write_beats_tick");

        // Wrap: FFFFFFFE -> FFFFFFFF -> 0 -> 1 (match), one-shot, IE=0.
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);
        wr(A_COUNT, 32'hFFFF_FFFE);
        wr(A_CMP, 32'd1);
        wr(A_CTRL, 32'h1);
        expect_c(A_COUNT, 32'hFFFF_FFFE, 1'b0, "wrap_fe");
        expect_c(A_COUNT, 32'hFFFF_FFFF, 1'b0, "wrap_ff");
        expect_c(A_COUNT, 32'h0,         1'b0, "wrap_0");
        expect_c(A_COUNT, 32'h1,         1'b0, "wrap_1");
        expect_c(A_STATUS, 32'h1,        1'b0, "wrap_pend_ie0");
        expect_c(A_CTRL,  32'h0,         1'b0, "wrap_stopped");

        // Bus decode.
        expect_c(32'h10, 32'h0, 1'b0, "read_unmapped_0x10");
        expect_c(32'h2,  32'h0, 1'b0, "read_misaligned_0x2");
        wr(32'h2, 32'hFFFF_FFFF);
        expect_c(A_CTRL, 32'h0, 1'b0, "misaligned_write_ignored");
        wr(32'h18, 32'd5);
        expect_c(A_COUNT, 32'h1, 1'b0, "unmapped_write_ignored");
        wr(A_STATUS, 32'h0);
        expect_c(A_STATUS, 32'h1, 1'b0, "status_write0_no_effect");

        // Randomized traffic against the model.
        wr(A_CTRL, 32'h0);
        for (int i = 0; i < 600; i++) begin
            logic        we;
            logic [31:0] a, d;
            logic        ack;
            we  = ($urandom_range(0, 99) < 25);
            a   = addr_tbl[$urandom_range(0, 6)];
            ack = ($urandom_range(0, 9) == 0);
            case (a)
                A_CTRL:   d = {16'h0, 8'($urandom_range(0, 3)), 5'h0, 3'($urandom_range(0, 7))};
                A_STATUS: d = 32'($urandom_range(0, 1));
                A_COUNT:  d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                          : 32'($urandom_range(0, 12));
                A_CMP:    d = 32'($urandom_range(0, 12));
                default:  d = $urandom;
            endcase
            cyc(we, a, d, ack, "random");
        end

        // Drain the scoreboard with a bounded wait.
        repeat (4) @(negedge clk);
        check(32'(exp_q.size()), 32'h0, "scoreboard_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_machine_timer
